// File: rtl/spi_slave_cont_if.sv
`default_nettype none
// =============================================================================
// Module   : spi_slave_cont_if
// Desc     : SPI pins plus local TX/RX handshake of spi_slave_cont.
//            SS_N exists only when SPI_SLV_SS_EN is defined.
// Revision : 1.0 - initial release
// =============================================================================
interface spi_slave_cont_if #(
  parameter int DW = 8
);
  logic          SCLK;
  logic          MOSI;
  logic          MISO;
`ifdef SPI_SLV_SS_EN
  logic          SS_N;
`endif
  logic          W_STB;
  logic [DW-1:0] W_DATA;
  logic          W_ACK;
  logic          W_FULL;
  logic [DW-1:0] R_DATA;
  logic          R_VLD;
  logic          R_ACK;
  logic          R_OVR;

  modport slave (
`ifdef SPI_SLV_SS_EN
    input  SS_N,
`endif
    input  SCLK, MOSI, W_STB, W_DATA, R_ACK,
    output MISO, W_ACK, W_FULL, R_DATA, R_VLD, R_OVR
  );

  modport master (
`ifdef SPI_SLV_SS_EN
    output SS_N,
`endif
    output SCLK, MOSI, W_STB, W_DATA, R_ACK,
    input  MISO, W_ACK, W_FULL, R_DATA, R_VLD, R_OVR
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_cont.sv
`default_nettype none
// =============================================================================
// Module   : spi_slave_cont
// Desc     : SPI mode-0 responder oversampled on CLK50, 1-deep TX holding
//            register, RX valid/ack handshake. `define SPI_SLV_SS_EN adds
//            SS_N framing; otherwise bit-count framing with idle abort.
// Revision : 1.0 - initial release
// =============================================================================
module spi_slave_cont #(
  parameter int            DW          = 8,
  parameter logic [DW-1:0] FILL        = 8'hFF,
  parameter int            SYNC_STAGES = 2,
  parameter int            IDLE_TO     = 64
) (
  input  logic            CLK50,
  input  logic            RST,
  spi_slave_cont_if.slave bus
);

  localparam int            BW       = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);
  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_SHIFT  = 1'b1;

  logic [SYNC_STAGES:0]   sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [0:0]             state_q, state_d;
  logic [BW-1:0]          bitcnt_q, bitcnt_d;
  logic [DW-1:0]          rx_sr_q, rx_sr_d;
  logic [DW-1:0]          tx_sr_q, tx_sr_d;
  logic [DW-1:0]          hold_q, hold_d;
  logic [DW-1:0]          r_data_q, r_data_d;
  logic                   tx_empty_q, tx_empty_d;
  logic                   skip_fall_q, skip_fall_d;
  logic                   w_full_q, w_full_d;
  logic                   w_ack_q, w_ack_d;
  logic                   r_vld_q, r_vld_d;
  logic                   r_ovr_q, r_ovr_d;

  logic          sclk_s, sclk_p, mosi_s;
  logic          sclk_rise, sclk_fall;
  logic          sel, rise, fall, abort, restart;
  logic          start, word_done, shift_out, reload;
  logic          w_accept, bind_now, tx_bit;
  logic [DW-1:0] rx_word;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sclk_p    = sclk_sync_q[SYNC_STAGES];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_p;
  assign sclk_fall = ~sclk_s & sclk_p;
  assign rx_word   = {rx_sr_q[DW-2:0], mosi_s};

`ifdef SPI_SLV_SS_EN
  logic [SYNC_STAGES:0] ss_sync_q, ss_sync_d;
  logic                 ss_s, ss_p;

  assign ss_s    = ss_sync_q[SYNC_STAGES-1];
  assign ss_p    = ss_sync_q[SYNC_STAGES];
  assign sel     = ~ss_s;
  assign restart = ~ss_s & ss_p;
  assign abort   = ss_s & ~ss_p & (state_q == S_SHIFT);
`else
  localparam int TW = $clog2(IDLE_TO + 1);
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;

  assign sel     = 1'b1;
  assign restart = 1'b0;
  assign abort   = (state_q == S_SHIFT) & ~sclk_rise & ~sclk_fall &
                   (idle_cnt_q == TW'(IDLE_TO - 1));
`endif

  assign rise = sclk_rise & sel & ~restart;
  assign fall = sclk_fall & sel & ~restart;

  // -------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rise && (bitcnt_q != LAST_BIT)) state_d = S_SHIFT;
      S_SHIFT: if ((rise && (bitcnt_q == LAST_BIT)) || abort) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (restart) state_d = S_IDLE;
  end

  always_comb begin
    start     = (state_q == S_IDLE) && rise;
    word_done = rise && (bitcnt_q == LAST_BIT);
    shift_out = fall && !skip_fall_q;
    reload    = word_done || abort || restart;
  end

  // -------------------------------------------------------------------------
  // Datapath next-state
  // -------------------------------------------------------------------------
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-1:0], bus.SCLK};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
`ifdef SPI_SLV_SS_EN
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-1:0], bus.SS_N};
`else
    idle_cnt_d  = '0;
    if ((state_q == S_SHIFT) && !sclk_rise && !sclk_fall && !abort)
      idle_cnt_d = idle_cnt_q + 1'b1;
`endif

    w_accept = bus.W_STB && !w_full_q;
    // A word that starts from an empty register picks up a late-loaded holding word
    bind_now = start && tx_empty_q && w_full_q && !reload;

    bitcnt_d = bitcnt_q;
    if (reload)    bitcnt_d = '0;
    else if (rise) bitcnt_d = bitcnt_q + 1'b1;

    rx_sr_d = rx_sr_q;
    if (abort || restart) rx_sr_d = '0;
    else if (rise)        rx_sr_d = rx_word;

    tx_sr_d    = tx_sr_q;
    tx_empty_d = tx_empty_q;
    if (reload) begin
      tx_sr_d    = w_full_q ? hold_q : FILL;
      tx_empty_d = !w_full_q;
    end else if (bind_now) begin
      tx_sr_d    = hold_q;
      tx_empty_d = 1'b0;
    end else if (shift_out) begin
      tx_sr_d    = {tx_sr_q[DW-2:0], 1'b0};
    end

    skip_fall_d = skip_fall_q;
    if (word_done)                     skip_fall_d = 1'b1;
    else if (fall || abort || restart) skip_fall_d = 1'b0;

    hold_d   = w_accept ? bus.W_DATA : hold_q;
    w_ack_d  = w_accept;
    w_full_d = w_full_q;
    if (w_accept)                            w_full_d = 1'b1;
    else if ((reload && w_full_q) || bind_now) w_full_d = 1'b0;

    r_data_d = r_data_q;
    r_vld_d  = r_vld_q;
    r_ovr_d  = 1'b0;
    if (word_done) begin
      if (!r_vld_q || bus.R_ACK) begin
        r_data_d = rx_word;
        r_vld_d  = 1'b1;
      end else begin
        r_ovr_d  = 1'b1;
      end
    end else if (bus.R_ACK) begin
      r_vld_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK50 or negedge RST) begin
    if (!RST) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
`ifdef SPI_SLV_SS_EN
      ss_sync_q   <= '1;
`else
      idle_cnt_q  <= '0;
`endif
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= FILL;
      tx_empty_q  <= 1'b1;
      skip_fall_q <= 1'b0;
      hold_q      <= '0;
      w_full_q    <= 1'b0;
      w_ack_q     <= 1'b0;
      r_data_q    <= '0;
      r_vld_q     <= 1'b0;
      r_ovr_q     <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
`ifdef SPI_SLV_SS_EN
      ss_sync_q   <= ss_sync_d;
`else
      idle_cnt_q  <= idle_cnt_d;
`endif
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      tx_empty_q  <= tx_empty_d;
      skip_fall_q <= skip_fall_d;
      hold_q      <= hold_d;
      w_full_q    <= w_full_d;
      w_ack_q     <= w_ack_d;
      r_data_q    <= r_data_d;
      r_vld_q     <= r_vld_d;
      r_ovr_q     <= r_ovr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign tx_bit = ((state_q == S_IDLE) && tx_empty_q && w_full_q) ? hold_q[DW-1]
                                                                  : tx_sr_q[DW-1];
`ifdef SPI_SLV_SS_EN
  assign bus.MISO = ss_s | tx_bit;
`else
  assign bus.MISO = tx_bit;
`endif
  assign bus.W_ACK  = w_ack_q;
  assign bus.W_FULL = w_full_q;
  assign bus.R_DATA = r_data_q;
  assign bus.R_VLD  = r_vld_q;
  assign bus.R_OVR  = r_ovr_q;

endmodule
`default_nettype wire
